// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: PLL reset/lock sequencer and per-channel dynamic phase-step driver
module pll_phase_ctrl #(
    parameter int NCH          = 3,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILT    = 64,
    parameter int LOSS_FILT    = 4,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int PULSE_W      = 4,
    parameter int GAP_W        = 8,
    parameter int STEP_W       = 8,
    parameter int PHASE_STEPS  = 64,
    localparam int PH_W        = $clog2(PHASE_STEPS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_lock,
    output logic                  pll_reset,
    output logic [2:0]            ps_sel,
    output logic                  ps_dir,
    output logic                  ps_pulse,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_ch,
    input  logic                  req_dir,
    input  logic [STEP_W-1:0]     req_steps,
    output logic                  done,
    output logic                  req_err,
    output logic                  locked,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [NCH*PH_W-1:0]   phase_pos
);
    localparam int CW = $clog2(LOCK_TIMEOUT + RST_CYCLES + PULSE_W + GAP_W + 1);
    localparam int HW = $clog2(LOCK_FILT + 1);
    localparam int LW = $clog2(LOSS_FILT + 1);

    typedef enum logic [2:0] {RST_HOLD, WAIT_LOCK, IDLE, PULSE_HI, PULSE_LO} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [STEP_W-1:0]    rem, rem_n;
    logic [HW-1:0]        hi_cnt;
    logic [LW-1:0]        lo_cnt;
    logic [1:0]           lock_ff;
    logic                 lock_s, lock_ok, lost, run, accept;
    logic                 done_n, err_n, tmo_n, dir_n;
    logic [2:0]           sel_n;
    logic [NCH*PH_W-1:0]  pos_n;
    logic [PH_W-1:0]      cur;

    assign lock_s  = lock_ff[1];
    assign lock_ok = lock_s && hi_cnt >= HW'(LOCK_FILT - 1);
    assign lost    = !lock_s && lo_cnt >= LW'(LOSS_FILT - 1);
    assign run     = state == IDLE || state == PULSE_HI || state == PULSE_LO;
    assign accept  = req_valid && req_ready;
    assign cur     = phase_pos[ps_sel*PH_W +: PH_W];

    // pll_lock is asynchronous; run lengths are measured on the synced copy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_ff <= '0;
            hi_cnt  <= '0;
            lo_cnt  <= '0;
        end else begin
            lock_ff <= {lock_ff[0], pll_lock};
            hi_cnt  <= !lock_s ? '0 : (hi_cnt == HW'(LOCK_FILT)) ? hi_cnt : hi_cnt + HW'(1);
            lo_cnt  <= lock_s ? '0 : (lo_cnt == LW'(LOSS_FILT)) ? lo_cnt : lo_cnt + LW'(1);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        rem_n   = rem;
        sel_n   = ps_sel;
        dir_n   = ps_dir;
        pos_n   = phase_pos;
        done_n  = 1'b0;
        err_n   = 1'b0;
        tmo_n   = err_timeout;
        case (state)
            RST_HOLD: begin
                pos_n = '0;
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_n = RST_HOLD;
                    cnt_n   = '0;
                    tmo_n   = 1'b1;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    if (int'(req_ch) >= NCH) err_n = 1'b1;
                    else if (req_steps == '0) done_n = 1'b1;
                    else begin
                        sel_n   = req_ch;
                        dir_n   = req_dir;
                        rem_n   = req_steps;
                        state_n = PULSE_HI;
                    end
                end
            end
            PULSE_HI: begin
                if (cnt == CW'(PULSE_W - 1)) begin
                    state_n = PULSE_LO;
                    cnt_n   = '0;
                    rem_n   = rem - STEP_W'(1);
                    pos_n[ps_sel*PH_W +: PH_W] = ps_dir ? cur + PH_W'(1) : cur - PH_W'(1);
                end
            end
            PULSE_LO: begin
                if (cnt == CW'(GAP_W - 1)) begin
                    cnt_n   = '0;
                    state_n = (rem == '0) ? IDLE : PULSE_HI;
                    done_n  = rem == '0;
                end
            end
            default: state_n = RST_HOLD;
        endcase
        // lock loss overrides any completion in the same cycle
        if (lost && run) begin
            state_n = RST_HOLD;
            cnt_n   = '0;
            pos_n   = '0;
            done_n  = 1'b0;
            err_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= RST_HOLD;
            cnt         <= '0;
            rem         <= '0;
            ps_sel      <= '0;
            ps_dir      <= 1'b0;
            phase_pos   <= '0;
            done        <= 1'b0;
            req_err     <= 1'b0;
            err_timeout <= 1'b0;
            pll_reset   <= 1'b1;
            ps_pulse    <= 1'b0;
            req_ready   <= 1'b0;
            locked      <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rem         <= rem_n;
            ps_sel      <= sel_n;
            ps_dir      <= dir_n;
            phase_pos   <= pos_n;
            done        <= done_n;
            req_err     <= err_n;
            err_timeout <= tmo_n;
            pll_reset   <= state_n == RST_HOLD;
            ps_pulse    <= state_n == PULSE_HI;
            req_ready   <= state_n == IDLE && !(state == IDLE && done_n);
            locked      <= state_n == IDLE || state_n == PULSE_HI || state_n == PULSE_LO;
            busy        <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: scoreboard bench for pll_phase_ctrl against a step-level phase model
module tb_pll_phase_ctrl;
    localparam int NCH = 3, PH_W = 6, PS = 64, PW = 4, GW = 8, TMO = 256, RSTC = 16;

    typedef struct {
        bit                  err;
        int                  cyc;
        logic [NCH*PH_W-1:0] pos;
    } exp_t;

    logic                clk = 0, resetn = 0, pll_lock = 0;
    logic                req_valid = 0, req_dir = 0;
    logic [2:0]          req_ch = 0;
    logic [7:0]          req_steps = 0;
    logic                pll_reset, ps_dir, ps_pulse, req_ready, done, req_err, locked, busy, err_timeout;
    logic [2:0]          ps_sel;
    logic [NCH*PH_W-1:0] phase_pos;

    pll_phase_ctrl #(.NCH(NCH), .LOCK_TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .ps_sel(ps_sel), .ps_dir(ps_dir), .ps_pulse(ps_pulse),
        .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_dir(req_dir),
        .req_steps(req_steps), .done(done), .req_err(req_err), .locked(locked),
        .busy(busy), .err_timeout(err_timeout), .phase_pos(phase_pos)
    );

    always #5 clk = ~clk;

    int   cyc;
    int   n_vec = 0, n_bad = 0;
    int   model_pos [NCH];
    exp_t q[$];
    int   npulse = 0, hi_run = 0, cur_ch = 0;
    bit   cur_dir = 0, abort_ok = 0, prev_rst = 1;
    int   rst_rise = -1, rst_fall = -1;

    always @(posedge clk or negedge resetn) cyc <= !resetn ? 0 : cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tfail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no event within bound, expected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [NCH*PH_W-1:0] model_vec();
        logic [NCH*PH_W-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*PH_W +: PH_W] = PH_W'(model_pos[c]);
        return v;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) model_pos[c] = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (ps_pulse) begin
                    hi_run++;
                    if (hi_run == 1) npulse++;
                    if (!abort_ok) begin
                        chk("ps_sel_hold", ps_sel, cur_ch);
                        chk("ps_dir_hold", ps_dir, cur_dir);
                    end
                end else begin
                    if (hi_run != 0 && !abort_ok) chk("pulse_width", hi_run, PW);
                    hi_run = 0;
                end
                if (pll_reset && !prev_rst) rst_rise = cyc;
                if (!pll_reset && prev_rst) rst_fall = cyc;
                if (done || req_err) begin
                    if (q.size() == 0) tfail("unexpected_response");
                    else begin
                        e = q.pop_front();
                        chk("resp_is_err", req_err, e.err);
                        chk("resp_is_done", done, !e.err);
                        chk("resp_cycle", cyc, e.cyc);
                        chk("resp_phase_pos", phase_pos, e.pos);
                    end
                end
            end
            prev_rst = pll_reset;
        end
    end

    task automatic do_req(input int ch, input bit dir, input int steps);
        exp_t e;
        int   n0;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            tfail("ready_wait");
            return;
        end
        req_ch = 3'(ch); req_dir = dir; req_steps = 8'(steps); req_valid = 1;
        e.err = ch >= NCH;
        if (!e.err) begin
            cur_ch  = ch;
            cur_dir = dir;
            model_pos[ch] = ((model_pos[ch] + (dir ? steps : -steps)) % PS + PS) % PS;
        end
        e.cyc = cyc + 1 + (e.err ? 0 : steps * (PW + GW));
        e.pos = model_vec();
        q.push_back(e);
        n0 = npulse;
        @(negedge clk);
        req_valid = 0;
        for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tfail("response_wait");
            q.delete();
        end
        chk("pulse_count", npulse - n0, e.err ? 0 : steps);
    endtask

    initial begin : main
        int r1;
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_ps_pulse", ps_pulse, 0);
        chk("rst_ps_sel", ps_sel, 0);
        chk("rst_ps_dir", ps_dir, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_req_err", req_err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 1);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_phase_pos", phase_pos, 0);

        resetn = 1;
        for (int i = 0; i < 40 && pll_reset; i++) @(negedge clk);
        chk("pll_reset_fall_cycle", cyc, RSTC);
        while (cyc < 30) @(negedge clk);
        pll_lock = 1;
        for (int i = 0; i < 200 && !locked; i++) @(negedge clk);
        if (!locked) tfail("power_up_lock");
        chk("lock_cycle_96pm1", cyc >= 95 && cyc <= 97, 1);
        chk("ready_after_lock", req_ready, 1);
        chk("idle_not_busy", busy, 0);

        do_req(2, 1, 3);
        do_req(0, 0, 1);
        chk("wrap_down", phase_pos[0 +: PH_W], 63);
        do_req(0, 1, 65);
        chk("wrap_up", phase_pos[0 +: PH_W], 0);
        do_req(5, 1, 4);
        do_req(1, 1, 0);
        for (int k = 0; k < 8; k++)
            do_req($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 12));

        // lock loss during step 2 of 5
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        r1 = npulse;
        req_ch = 1; req_dir = 1; req_steps = 5; req_valid = 1;
        cur_ch = 1; cur_dir = 1;
        @(negedge clk);
        req_valid = 0;
        for (int i = 0; i < 100 && npulse < r1 + 2; i++) @(negedge clk);
        if (npulse < r1 + 2) tfail("second_pulse_wait");
        abort_ok = 1;
        pll_lock = 0;
        repeat (10) @(negedge clk);
        pll_lock = 1;
        clear_model();
        chk("loss_pll_reset", pll_reset, 1);
        chk("loss_ps_pulse", ps_pulse, 0);
        chk("loss_locked", locked, 0);
        chk("loss_phase_pos", phase_pos, 0);
        for (int i = 0; i < 40 && pll_reset; i++) @(negedge clk);
        @(negedge clk);
        chk("loss_reset_len", rst_fall - rst_rise, RSTC);
        for (int i = 0; i < 300 && !locked; i++) @(negedge clk);
        if (!locked) tfail("relock");
        chk("relock_phase_pos", phase_pos, 0);
        abort_ok = 0;
        do_req(2, 0, 2);

        // reset in the middle of a request
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        req_ch = 0; req_dir = 1; req_steps = 5; req_valid = 1;
        cur_ch = 0; cur_dir = 1;
        @(negedge clk);
        req_valid = 0;
        repeat (8) @(negedge clk);
        abort_ok = 1;
        resetn = 0;
        pll_lock = 0;
        clear_model();
        @(negedge clk);
        chk("mid_rst_ps_pulse", ps_pulse, 0);
        chk("mid_rst_phase_pos", phase_pos, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_pll_reset", pll_reset, 1);

        // lock never arrives: timeout and retry
        resetn = 1;
        for (int i = 0; i < 400 && !err_timeout; i++) @(negedge clk);
        chk("timeout_cycle", cyc, RSTC + TMO);
        @(negedge clk);
        chk("retry_reset_rise", rst_rise, RSTC + TMO);
        r1 = rst_rise;
        for (int i = 0; i < 400 && rst_rise == r1; i++) @(negedge clk);
        chk("retry_period", rst_rise - r1, RSTC + TMO);
        chk("timeout_sticky", err_timeout, 1);
        chk("timeout_locked", locked, 0);
        chk("no_stray_response", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        tfail("global_watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Sequencing and dynamic-phase controller for a Gowin PLLA instance with up to 7 output channels. Holds the PLL in reset at power-up, qualifies LOCK, and recovers from lock loss with a re-reset. Once locked, accepts per-channel phase-step requests and drives the PSSEL/PSDIR/PSPULSE pins, tracking each channel's phase position. Sits between the board PLL wrapper and the clocking/retiming logic (e.g. SDRAM clock skew tuning).

## Interface
- NCH, 3: number of phase-controllable channels (1..7).
- RST_CYCLES, 16: cycles `pll_reset` is held high per reset attempt.
- LOCK_FILT, 64: consecutive synced-high LOCK cycles required to declare lock.
- LOSS_FILT, 4: consecutive synced-low LOCK cycles to declare lock loss.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retry.
- PULSE_W, 4: `ps_pulse` high width, in cycles.
- GAP_W, 8: `ps_pulse` low time after each pulse, in cycles.
- STEP_W, 8: width of `req_steps`.
- PHASE_STEPS, 64: phase positions per channel. Must be a power of 2. PH_W = log2(PHASE_STEPS).

Ports:
- clk  in  1  free-running controller clock. Not a PLL output.
- resetn  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK. Asynchronous to `clk`.
- pll_reset  out  1  to PLL RESET, active high.
- ps_sel  out  3  to PSSEL, selected channel.
- ps_dir  out  1  to PSDIR.
- ps_pulse  out  1  to PSPULSE.
- req_valid  in  1  phase-step request.
- req_ready  out  1  request can be accepted.
- req_ch  in  3  target channel (0..NCH-1).
- req_dir  in  1  1 = advance (+1 per step), 0 = retard (-1 per step).
- req_steps  in  STEP_W  number of steps.
- done  out  1  one-cycle pulse when a request completes.
- req_err  out  1  one-cycle pulse when a request is rejected.
- locked  out  1  qualified lock.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  sticky flag: at least one lock timeout has occurred.
- phase_pos  out  NCH*PH_W  per-channel position. Channel c occupies bits [c*PH_W +: PH_W].

## Operation
- LOCK path: 2-FF synchronizer, then `lock_s`. Two counters track runs of `lock_s` high and `lock_s` low.
- States: RST_HOLD, WAIT_LOCK, IDLE, PULSE_HI, PULSE_LO.
- RST_HOLD:
  - `pll_reset`=1 for RST_CYCLES cycles, then go to WAIT_LOCK.
  - All `phase_pos` cleared to 0, because a PLL reset restores the static phases.
- WAIT_LOCK:
  - `pll_reset`=0.
  - After LOCK_FILT consecutive `lock_s`=1 cycles: `locked`=1, go to IDLE.
  - After LOCK_TIMEOUT cycles without qualifying: set `err_timeout`, go to RST_HOLD (retry indefinitely).
- IDLE: `req_ready`=1. Accept on `req_valid & req_ready`.
  - `req_ch` >= NCH: pulse `req_err`, stay in IDLE.
  - `req_steps`=0: pulse `done` in the next cycle, stay in IDLE.
  - Otherwise: latch `ps_sel`=`req_ch`, `ps_dir`=`req_dir`, remaining=`req_steps`; go to PULSE_HI.
- PULSE_HI: `ps_pulse`=1 for PULSE_W cycles. On exit:
  - `phase_pos[ch]` += 1 if `ps_dir`=1, else -= 1, modulo PHASE_STEPS (wraps 63->0 and 0->63).
  - remaining decrements.
- PULSE_LO: `ps_pulse`=0 for GAP_W cycles. On exit: if remaining=0, go to IDLE and pulse `done`; else go to PULSE_HI.
- Lock loss: LOSS_FILT consecutive `lock_s`=0 cycles in IDLE, PULSE_HI or PULSE_LO.
  - `locked`=0, `ps_pulse`=0 immediately, go to RST_HOLD.
  - Any in-flight request is aborted; `done` is not pulsed.
- `ps_sel` and `ps_dir` are stable for the whole request, including the final gap.

## Timing
- Reset values (resetn=0):
  - state RST_HOLD, `pll_reset`=1.
  - `ps_pulse`=0, `ps_sel`=0, `ps_dir`=0.
  - `req_ready`=0, `done`=0, `req_err`=0, `locked`=0.
  - `busy`=1, `err_timeout`=0, `phase_pos`=0.
- Reset mid-request: same values as above; the request is dropped.
- Lock qualification: `locked` rises 2 + LOCK_FILT cycles after `pll_lock` rises, given WAIT_LOCK is active.
- Accept to pulse: `ps_pulse` rises in the cycle after acceptance.
- Per step: N steps take N*(PULSE_W+GAP_W) cycles. `done` pulses in the cycle after the last gap cycle; `req_ready` is 1 in that same cycle.
- `phase_pos` updates in the cycle `ps_pulse` falls.
- All outputs are registered. `req_ready` = (state==IDLE) && !`done`-pending.
- Lock loss and a step completing in the same cycle: lock loss wins. `done` is suppressed and `phase_pos` is cleared.

## Test plan
- Power-up, with RST_CYCLES=16, LOCK_FILT=64 and `pll_lock` high from cycle 30 -> `pll_reset` high cycles 0-15; `locked` rises at cycle 96 (±1); `req_ready`=1 after.
- Request ch=2, dir=1, steps=3, PULSE_W=4, GAP_W=8 -> 3 pulses each 4 cycles high, `ps_sel`=2, `ps_dir`=1; `done` 36 cycles after accept; `phase_pos[2]`=3.
- Wrap: ch=0 retard 1 step from 0 -> `phase_pos[0]`=63. Then advance 65 steps -> `phase_pos[0]`=0.
- Rejects and no-ops: ch=5 with NCH=3 -> `req_err` pulse, no `ps_pulse` activity, `phase_pos` unchanged. steps=0 -> `done` next cycle, no pulse.
- Lock loss mid-request: drop `pll_lock` for 10 cycles during step 2 of 5 -> `ps_pulse` forced to 0, no `done`, `locked`=0, `pll_reset` for 16 cycles, all `phase_pos`=0, relock on restore.
- Timeout: hold `pll_lock`=0 with LOCK_TIMEOUT=256 -> `err_timeout` set at cycle 16+256 and stays set; `pll_reset` re-pulses every 272 cycles.
